// File: rtl/jtag_tap_sequencer.sv
// Command-driven JTAG master: walks the 1149.1 TAP for DR/IR scans of 1..MAX_LEN bits or a TAP reset.
// Latency: rsp_valid rises 1 + 2*CLK_DIV*TCKs clks after accept (DR len+5, IR len+6, reset 6 TCKs).
// Backpressure: cmd_ready low from accept until the response is taken; rsp_data held stable until rsp_ready.
module jtag_tap_sequencer #(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [5:0]         cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   input  logic               tdo,
   output logic               busy
);
   localparam int          IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [5:0]  LEN_CAP  = 6'(MAX_LEN);
   localparam logic [1:0]  OP_DR    = 2'd0;
   localparam logic [1:0]  OP_IR    = 2'd1;

   typedef enum logic [2:0] {IDLE, HDR, SHIFT, TRL, RESP} state_t;

   typedef struct packed {
      logic [1:0]         op;
      logic [5:0]         len;
      logic [MAX_LEN-1:0] data;
   } cmd_t;

   // Index of the last header TCK; ops 2 and 3 both walk the TAP reset path.
   function automatic logic [5:0] hdr_last(input logic [1:0] op);
      case (op)
         OP_DR:   hdr_last = 6'd2;
         OP_IR:   hdr_last = 6'd3;
         default: hdr_last = 6'd5;
      endcase
   endfunction

   function automatic logic hdr_tms(input logic [1:0] op, input logic [5:0] i);
      case (op)
         OP_DR:   hdr_tms = (i == 6'd0);
         OP_IR:   hdr_tms = (i < 6'd2);
         default: hdr_tms = (i < 6'd5);
      endcase
   endfunction

   state_t      state;
   cmd_t        cur;
   logic [5:0]  idx;
   logic [15:0] div_cnt;
   logic [5:0]  len_clamped;
   logic [5:0]  idx_nx;
   logic        shift_last;
   logic        phase_end;

   assign len_clamped = (cmd_len > LEN_CAP) ? LEN_CAP : cmd_len;
   assign idx_nx      = idx + 6'd1;
   assign shift_last  = (idx == cur.len - 6'd1);
   assign phase_end   = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cur       <= '0;
         idx       <= '0;
         div_cnt   <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         tck       <= 1'b0;
         tms       <= 1'b0;
         tdi       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cur       <= '{op: cmd_op, len: len_clamped, data: cmd_data};
                  rsp_data  <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  idx       <= '0;
                  div_cnt   <= '0;
                  tck       <= 1'b0;
                  if (!cmd_op[1] && cmd_len == 6'd0) begin
                     state <= RESP;
                  end else begin
                     state <= HDR;
                     tms   <= 1'b1;
                     tdi   <= 1'b0;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            HDR, SHIFT, TRL: begin
               if (!phase_end) begin
                  div_cnt <= div_cnt + 16'd1;
               end else begin
                  div_cnt <= '0;
                  if (!tck) begin
                     tck <= 1'b1;
                     if (state == SHIFT) rsp_data[idx[IW-1:0]] <= tdo;
                  end else begin
                     // Falling TCK: present tms/tdi for the next TCK or leave the scan.
                     tck <= 1'b0;
                     case (state)
                        HDR: begin
                           if (idx == hdr_last(cur.op)) begin
                              idx <= '0;
                              if (cur.op[1]) begin
                                 state <= RESP;
                              end else begin
                                 state <= SHIFT;
                                 tms   <= (cur.len == 6'd1);
                                 tdi   <= cur.data[0];
                              end
                           end else begin
                              idx <= idx_nx;
                              tms <= hdr_tms(cur.op, idx_nx);
                           end
                        end
                        SHIFT: begin
                           if (shift_last) begin
                              idx   <= '0;
                              state <= TRL;
                              tms   <= 1'b1;
                              tdi   <= 1'b0;
                           end else begin
                              idx <= idx_nx;
                              tms <= (idx_nx == cur.len - 6'd1);
                              tdi <= cur.data[idx_nx[IW-1:0]];
                           end
                        end
                        default: begin
                           if (idx == 6'd0) begin
                              idx <= 6'd1;
                              tms <= 1'b0;
                           end else begin
                              idx   <= '0;
                              state <= RESP;
                           end
                        end
                     endcase
                  end
               end
            end
            RESP: begin
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
